game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Frame-paced game sequencer that drives color_mapper's status inputs: death, reversal, lives, closePacman and the per-ghost enables.
- Consumes collision, pellet and level-clear events from the movement/collision logic.
- Emits freeze and respawn controls for the sprite position controllers.
- All timing counts frames, using a one-cycle frame_tick derived from VGA vsync.

Parameters:
START_LIVES, 3, lives loaded on start; range 1..3 (2-bit lives port)
FRIGHT_FRAMES, 360, frame_ticks spent in frightened (reversal) mode
DYING_FRAMES, 120, frame_ticks of death freeze before respawn or game over
READY_FRAMES, 60, frame_ticks of freeze after (re)spawn before play
MOUTH_FRAMES, 8, frame_ticks per closePacman toggle

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-Clk pulse per video frame
start  in  1  level-sensitive start request (keypress)
hit_red  in  1  pacman overlaps red ghost this cycle
hit_green  in  1  pacman overlaps green ghost this cycle
hit_aqua  in  1  pacman overlaps aqua ghost this cycle
pellet_eaten  in  1  one-cycle pulse, power pellet consumed
level_clear  in  1  one-cycle pulse, all dots eaten
death  out  1  game-over display select
reversal  out  1  frightened mode, ghosts drawn blue
lives  out  2  remaining lives
closePacman  out  1  mouth-closed animation frame
red_enable  out  1  red ghost active and visible
green_enable  out  1  green ghost active and visible
aqua_enable  out  1  aqua ghost active and visible
freeze  out  1  sprite controllers hold position
respawn  out  1  one-Clk pulse, sprite controllers reload start positions
state  out  3  current FSM state (debug)

Behaviour:
Reset and sampling:
- Reset_n=0, asynchronous: state=IDLE; lives=START_LIVES; death=0; reversal=0; closePacman=0; all enables=1; freeze=1; respawn=0; all counters=0.
- All outputs are registered. Events are sampled on the Clk edge; the response is visible the next cycle.

Counters:
- A single timer, width $clog2(max parameter+1), is loaded on state entry and decrements only on cycles where frame_tick=1.
- A state exits on the frame_tick edge at which timer==1. The state therefore lasts exactly N frame_ticks after entry.

States and transitions:
- IDLE (0), freeze=1. When start=1: respawn pulse, timer=READY_FRAMES, go to READY.
- READY (1), freeze=1, enables=1, reversal=0. On timer expiry: go to PLAY, freeze=0, mouth counter cleared, closePacman=0.
- PLAY (2):
  - Any hit_x with x_enable=1 goes to DYING, timer=DYING_FRAMES, freeze=1.
  - Otherwise, level_clear goes to READY with a respawn pulse, timer=READY_FRAMES, lives unchanged.
  - Otherwise, pellet_eaten goes to FRIGHT, reversal=1, timer=FRIGHT_FRAMES.
  - Priority is hit > level_clear > pellet.
- FRIGHT (3), reversal=1:
  - Each asserted hit_x with x_enable=1 clears x_enable (ghost eaten). Multiple hits in one cycle clear all of them. No death.
  - pellet_eaten reloads the timer to FRIGHT_FRAMES; eaten ghosts stay disabled.
  - level_clear goes to READY with a respawn pulse and reversal=0; it has priority over pellet.
  - On timer expiry: go to PLAY, reversal=0, all enables=1.
- DYING (4), freeze=1, closePacman=0. On expiry:
  - If lives==1: lives=0, death=1, go to GAME_OVER.
  - Otherwise: lives-=1, respawn pulse, timer=READY_FRAMES, go to READY.
- GAME_OVER (5), death=1, freeze=1, sticky. start=1 reloads lives=START_LIVES, clears death, pulses respawn, goes to READY.

Event filtering:
- Hits with the corresponding enable=0 are ignored in every state.
- All events are ignored in IDLE, READY and DYING, except start where listed.

Mouth animation:
- In PLAY/FRIGHT only, the mouth counter counts frame_ticks and toggles closePacman every MOUTH_FRAMES ticks.
- Outside PLAY/FRIGHT, closePacman=0 and the counter is cleared.

Outputs and encoding:
- respawn is exactly one Clk wide per transition.
- lives never underflows below 0.
- Unused state encodings (6, 7) recover to IDLE on the next Clk.
- Reset mid-operation returns to IDLE regardless of state or counter values.

Test Plan:
All scenarios use FRIGHT_FRAMES=4, DYING_FRAMES=3, READY_FRAMES=2, MOUTH_FRAMES=2, START_LIVES=3, with frame_tick every 10 Clk.
- Reset, start pulse -> respawn high for 1 Clk, state=1; after 2 ticks state=2, freeze=0, lives=3, all enables=1.
- In PLAY, pellet_eaten -> reversal=1 next Clk. hit_red mid-fright -> red_enable=0, state stays 3. After the 4th tick -> reversal=0, red_enable=1, state=2.
- In PLAY, hit_green -> state=4, freeze=1. After 3 ticks -> lives=2, respawn pulse, state=1. Repeat twice -> lives=0, death=1, state=5. start -> lives=3, death=0.
- Same-cycle hit_aqua+level_clear in PLAY -> DYING (lives unchanged until expiry). Same-cycle pellet+level_clear -> READY, reversal=0.
- In FRIGHT at timer==1, pellet_eaten with no tick -> timer reloads to 4, fright lasts 4 more ticks. hit_red while red_enable=0 -> no change.
- closePacman toggles every 2 ticks in PLAY and is held 0 in DYING. Reset_n low mid-DYING -> all outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: frame-paced game sequencer for the pacman display path.
// Tracks lives, frightened mode, per-ghost visibility, the pacman mouth
// animation and freeze/respawn handshakes to the sprite controllers.
// All durations are counted in frame_tick pulses.

module game_flow_ctrl #(
  parameter int START_LIVES   = 3,
  parameter int FRIGHT_FRAMES = 360,
  parameter int DYING_FRAMES  = 120,
  parameter int READY_FRAMES  = 60,
  parameter int MOUTH_FRAMES  = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       hit_red,
  input  logic       hit_green,
  input  logic       hit_aqua,
  input  logic       pellet_eaten,
  input  logic       level_clear,
  output logic       death,
  output logic       reversal,
  output logic [1:0] lives,
  output logic       closePacman,
  output logic       red_enable,
  output logic       green_enable,
  output logic       aqua_enable,
  output logic       freeze,
  output logic       respawn,
  output logic [2:0] state
);

  // Largest of the three state durations sets the shared timer width.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int TW = $clog2(max3(FRIGHT_FRAMES, DYING_FRAMES, READY_FRAMES) + 1);
  localparam int MW = $clog2(MOUTH_FRAMES + 1);

  localparam logic [TW-1:0] T_FRIGHT   = TW'(FRIGHT_FRAMES);
  localparam logic [TW-1:0] T_DYING    = TW'(DYING_FRAMES);
  localparam logic [TW-1:0] T_READY    = TW'(READY_FRAMES);
  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [MW-1:0] MOUTH_LAST = MW'(MOUTH_FRAMES - 1);
  localparam logic [MW-1:0] MOUTH_ONE  = MW'(1);
  localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READY     = 3'd1,
    PLAY      = 3'd2,
    FRIGHT    = 3'd3,
    DYING     = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   timer_r;
  logic [MW-1:0]   mouth_cnt_r;
  logic [1:0]      lives_r;
  logic            death_r;
  logic            reversal_r;
  logic            close_r;
  logic            red_en_r;
  logic            green_en_r;
  logic            aqua_en_r;
  logic            freeze_r;
  logic            respawn_r;

  logic            hit_any_s;
  logic            timer_exp_s;
  logic            mouth_wrap_s;
  logic            mouth_active_s;

  // Qualified event decode: disabled ghosts never count as a hit.
  always_comb begin
    hit_any_s      = (hit_red & red_en_r) | (hit_green & green_en_r) | (hit_aqua & aqua_en_r);
    timer_exp_s    = frame_tick & (timer_r <= T_ONE);
    mouth_wrap_s   = (mouth_cnt_r == MOUTH_LAST);
    mouth_active_s = (state_r == PLAY) || (state_r == FRIGHT);
  end

  // Game sequencer: state, timer, mouth animation and all registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      timer_r     <= '0;
      mouth_cnt_r <= '0;
      lives_r     <= LIVES_INIT;
      death_r     <= 1'b0;
      reversal_r  <= 1'b0;
      close_r     <= 1'b0;
      red_en_r    <= 1'b1;
      green_en_r  <= 1'b1;
      aqua_en_r   <= 1'b1;
      freeze_r    <= 1'b1;
      respawn_r   <= 1'b0;
    end else begin
      respawn_r <= 1'b0;

      // Mouth runs only while pacman moves; transitions below may override.
      if (mouth_active_s) begin
        if (frame_tick) begin
          if (mouth_wrap_s) begin
            mouth_cnt_r <= '0;
            close_r     <= ~close_r;
          end else begin
            mouth_cnt_r <= mouth_cnt_r + MOUTH_ONE;
          end
        end
      end else begin
        mouth_cnt_r <= '0;
        close_r     <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          freeze_r <= 1'b1;
          if (start) begin
            respawn_r <= 1'b1;
            timer_r   <= T_READY;
            state_r   <= READY;
          end
        end

        READY: begin
          freeze_r   <= 1'b1;
          reversal_r <= 1'b0;
          red_en_r   <= 1'b1;
          green_en_r <= 1'b1;
          aqua_en_r  <= 1'b1;
          if (timer_exp_s) begin
            state_r     <= PLAY;
            freeze_r    <= 1'b0;
            mouth_cnt_r <= '0;
            close_r     <= 1'b0;
          end else if (frame_tick) begin
            timer_r <= timer_r - T_ONE;
          end
        end

        PLAY: begin
          if (hit_any_s) begin
            state_r     <= DYING;
            timer_r     <= T_DYING;
            freeze_r    <= 1'b1;
            mouth_cnt_r <= '0;
            close_r     <= 1'b0;
          end else if (level_clear) begin
            state_r     <= READY;
            respawn_r   <= 1'b1;
            timer_r     <= T_READY;
            freeze_r    <= 1'b1;
            mouth_cnt_r <= '0;
            close_r     <= 1'b0;
          end else if (pellet_eaten) begin
            state_r    <= FRIGHT;
            reversal_r <= 1'b1;
            timer_r    <= T_FRIGHT;
          end
        end

        FRIGHT: begin
          if (level_clear) begin
            state_r     <= READY;
            respawn_r   <= 1'b1;
            timer_r     <= T_READY;
            reversal_r  <= 1'b0;
            red_en_r    <= 1'b1;
            green_en_r  <= 1'b1;
            aqua_en_r   <= 1'b1;
            freeze_r    <= 1'b1;
            mouth_cnt_r <= '0;
            close_r     <= 1'b0;
          end else begin
            // Ghosts touched while frightened are eaten and vanish.
            red_en_r   <= red_en_r   & ~hit_red;
            green_en_r <= green_en_r & ~hit_green;
            aqua_en_r  <= aqua_en_r  & ~hit_aqua;
            if (pellet_eaten) begin
              timer_r <= T_FRIGHT;
            end else if (timer_exp_s) begin
              state_r    <= PLAY;
              reversal_r <= 1'b0;
              red_en_r   <= 1'b1;
              green_en_r <= 1'b1;
              aqua_en_r  <= 1'b1;
            end else if (frame_tick) begin
              timer_r <= timer_r - T_ONE;
            end
          end
        end

        DYING: begin
          freeze_r <= 1'b1;
          if (timer_exp_s) begin
            if (lives_r <= 2'd1) begin
              lives_r <= 2'd0;
              death_r <= 1'b1;
              state_r <= GAME_OVER;
            end else begin
              lives_r   <= lives_r - 2'd1;
              respawn_r <= 1'b1;
              timer_r   <= T_READY;
              state_r   <= READY;
            end
          end else if (frame_tick) begin
            timer_r <= timer_r - T_ONE;
          end
        end

        GAME_OVER: begin
          death_r  <= 1'b1;
          freeze_r <= 1'b1;
          if (start) begin
            lives_r    <= LIVES_INIT;
            death_r    <= 1'b0;
            respawn_r  <= 1'b1;
            timer_r    <= T_READY;
            reversal_r <= 1'b0;
            red_en_r   <= 1'b1;
            green_en_r <= 1'b1;
            aqua_en_r  <= 1'b1;
            state_r    <= READY;
          end
        end

        default: begin
          // Illegal encodings fall back to the power-on condition.
          state_r     <= IDLE;
          timer_r     <= '0;
          mouth_cnt_r <= '0;
          lives_r     <= LIVES_INIT;
          death_r     <= 1'b0;
          reversal_r  <= 1'b0;
          close_r     <= 1'b0;
          red_en_r    <= 1'b1;
          green_en_r  <= 1'b1;
          aqua_en_r   <= 1'b1;
          freeze_r    <= 1'b1;
        end
      endcase
    end
  end

  assign death        = death_r;
  assign reversal     = reversal_r;
  assign lives        = lives_r;
  assign closePacman  = close_r;
  assign red_enable   = red_en_r;
  assign green_enable = green_en_r;
  assign aqua_enable  = aqua_en_r;
  assign freeze       = freeze_r;
  assign respawn      = respawn_r;
  assign state        = state_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl with short frame timings.

module tb_game_flow_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic       frame_tick;
  logic       start;
  logic       hit_red;
  logic       hit_green;
  logic       hit_aqua;
  logic       pellet_eaten;
  logic       level_clear;
  logic       death;
  logic       reversal;
  logic [1:0] lives;
  logic       closePacman;
  logic       red_enable;
  logic       green_enable;
  logic       aqua_enable;
  logic       freeze;
  logic       respawn;
  logic [2:0] state;

  int checks_cnt = 0;
  int errors_cnt = 0;

  game_flow_ctrl #(
    .START_LIVES  (3),
    .FRIGHT_FRAMES(4),
    .DYING_FRAMES (3),
    .READY_FRAMES (2),
    .MOUTH_FRAMES (2)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_tick  (frame_tick),
    .start       (start),
    .hit_red     (hit_red),
    .hit_green   (hit_green),
    .hit_aqua    (hit_aqua),
    .pellet_eaten(pellet_eaten),
    .level_clear (level_clear),
    .death       (death),
    .reversal    (reversal),
    .lives       (lives),
    .closePacman (closePacman),
    .red_enable  (red_enable),
    .green_enable(green_enable),
    .aqua_enable (aqua_enable),
    .freeze      (freeze),
    .respawn     (respawn),
    .state       (state)
  );

  // Free-running 10-unit clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input int act, input int exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Nine quiet cycles then one frame_tick cycle; returns just after that edge.
  task automatic frame();
    repeat (9) @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Apply a one-cycle event combination, then clear it.
  task automatic pulse(input logic st, input logic hr, input logic hg, input logic ha,
                       input logic pe, input logic lc);
    start = st; hit_red = hr; hit_green = hg; hit_aqua = ha;
    pellet_eaten = pe; level_clear = lc;
    @(negedge Clk);
    start = 1'b0; hit_red = 1'b0; hit_green = 1'b0; hit_aqua = 1'b0;
    pellet_eaten = 1'b0; level_clear = 1'b0;
  endtask

  function automatic int en3();
    return int'({red_enable, green_enable, aqua_enable});
  endfunction

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
    hit_red = 1'b0; hit_green = 1'b0; hit_aqua = 1'b0;
    pellet_eaten = 1'b0; level_clear = 1'b0;
    repeat (2) @(negedge Clk);

    // Reset values
    check_val("rst_state", int'(state), 0);
    check_val("rst_lives", int'(lives), 3);
    check_val("rst_death", int'(death), 0);
    check_val("rst_rev", int'(reversal), 0);
    check_val("rst_close", int'(closePacman), 0);
    check_val("rst_en", en3(), 7);
    check_val("rst_freeze", int'(freeze), 1);
    check_val("rst_respawn", int'(respawn), 0);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_val("idle_hold", int'(state), 0);

    // Start game
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("start_state", int'(state), 1);
    check_val("start_respawn", int'(respawn), 1);
    check_val("start_freeze", int'(freeze), 1);
    @(negedge Clk);
    check_val("start_respawn_1clk", int'(respawn), 0);
    frame();
    check_val("ready_tick1", int'(state), 1);
    frame();
    check_val("play_state", int'(state), 2);
    check_val("play_freeze", int'(freeze), 0);
    check_val("play_lives", int'(lives), 3);
    check_val("play_en", en3(), 7);
    check_val("play_close0", int'(closePacman), 0);

    // Mouth toggles every 2 ticks
    frame(); check_val("mouth_t1", int'(closePacman), 0);
    frame(); check_val("mouth_t2", int'(closePacman), 1);
    frame(); check_val("mouth_t3", int'(closePacman), 1);
    frame(); check_val("mouth_t4", int'(closePacman), 0);

    // Frightened mode, ghost eaten, pellet reload at timer==1
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("fr_state", int'(state), 3);
    check_val("fr_rev", int'(reversal), 1);
    frame();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("fr_eat_red_en", en3(), 3);
    check_val("fr_eat_state", int'(state), 3);
    frame();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("fr_red_ignored_en", en3(), 3);
    check_val("fr_red_ignored_st", int'(state), 3);
    frame();
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("fr_reload_state", int'(state), 3);
    check_val("fr_reload_en", en3(), 3);
    frames(3);
    check_val("fr_reload_3ticks_st", int'(state), 3);
    check_val("fr_reload_3ticks_rev", int'(reversal), 1);
    frame();
    check_val("fr_end_state", int'(state), 2);
    check_val("fr_end_rev", int'(reversal), 0);
    check_val("fr_end_en", en3(), 7);
    check_val("fr_end_close", int'(closePacman), 1);

    // Death with lives remaining
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("die_state", int'(state), 4);
    check_val("die_freeze", int'(freeze), 1);
    check_val("die_close", int'(closePacman), 0);
    check_val("die_lives", int'(lives), 3);
    check_val("die_respawn", int'(respawn), 0);
    frame();
    check_val("die_t1_close", int'(closePacman), 0);
    frame();
    check_val("die_t2_state", int'(state), 4);
    frame();
    check_val("die_end_state", int'(state), 1);
    check_val("die_end_lives", int'(lives), 2);
    check_val("die_end_respawn", int'(respawn), 1);
    @(negedge Clk);
    check_val("die_respawn_1clk", int'(respawn), 0);
    frames(2);
    check_val("play2_state", int'(state), 2);

    // Hit beats level_clear
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("hit_lc_state", int'(state), 4);
    check_val("hit_lc_lives", int'(lives), 2);
    frames(3);
    check_val("die2_lives", int'(lives), 1);
    check_val("die2_state", int'(state), 1);
    frames(2);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("die3_state", int'(state), 4);
    frames(3);
    check_val("go_state", int'(state), 5);
    check_val("go_lives", int'(lives), 0);
    check_val("go_death", int'(death), 1);
    check_val("go_freeze", int'(freeze), 1);
    check_val("go_respawn", int'(respawn), 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("go_sticky", int'(state), 5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("restart_state", int'(state), 1);
    check_val("restart_lives", int'(lives), 3);
    check_val("restart_death", int'(death), 0);
    check_val("restart_respawn", int'(respawn), 1);
    frames(2);
    check_val("play3_state", int'(state), 2);

    // level_clear beats pellet in PLAY and in FRIGHT
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("lc_play_state", int'(state), 1);
    check_val("lc_play_rev", int'(reversal), 0);
    check_val("lc_play_respawn", int'(respawn), 1);
    frames(2);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("fr2_state", int'(state), 3);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("lc_fr_state", int'(state), 1);
    check_val("lc_fr_rev", int'(reversal), 0);
    check_val("lc_fr_respawn", int'(respawn), 1);
    check_val("lc_fr_lives", int'(lives), 3);
    frames(2);

    // Async reset while dying, after one life already lost
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frames(3);
    check_val("pre_rst_lives", int'(lives), 2);
    frames(2);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame();
    check_val("pre_rst_state", int'(state), 4);
    #2 Reset_n = 1'b0;
    #1;
    check_val("arst_state", int'(state), 0);
    check_val("arst_lives", int'(lives), 3);
    check_val("arst_freeze", int'(freeze), 1);
    check_val("arst_en", en3(), 7);
    check_val("arst_death", int'(death), 0);
    check_val("arst_rev", int'(reversal), 0);
    check_val("arst_respawn", int'(respawn), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
